timer_multi_core: RTL and testbench
===================================

# timer_multi_core

Parametrised multi-channel interval timer, the next generation of the single-channel timer core. It provides CH independent up-counters of WIDTH bits, driven by a shared programmable prescaler. Each channel runs in one-shot or continuous mode, with a sticky interrupt flag and per-channel clear. It sits between the register file (control, period and prescale fields) and the interrupt aggregation logic.

## Interface
- WIDTH, 16, counter and period width per channel (2..32)
- CH, 4, number of channels (1..16)
- PRE_W, 8, prescaler divide-field width
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_prescale  input  PRE_W  tick divider; one tick every i_prescale+1 clocks
- i_en  input  CH  per-channel enable (level)
- i_cont  input  CH  per-channel mode; 1 = continuous, 0 = one-shot
- i_irq_clear  input  CH  per-channel clear strobe (one cycle)
- i_period  input  CH*WIDTH  per-channel period; channel k in bits [k*WIDTH +: WIDTH]
- o_irq  output  CH  sticky per-channel interrupt flags
- o_irq_any  output  1  OR of o_irq, registered
- o_expire  output  CH  one-clock pulse per expiry event
- o_count  output  CH*WIDTH  live counter values
- o_done  output  CH  one-shot channel has expired and is halted

## Operation
- Prescaler: a PRE_W-bit down-counter shared by all channels. Loads i_prescale on reset and on reaching 0, and asserts internal tick for one clock when at 0. i_prescale = 0 gives a tick every clock. A new i_prescale takes effect at the next reload.
- Per-channel FSM states:
  - IDLE: count 0, o_done 0.
  - RUN: counting.
  - DONE: one-shot expired; count holds at 0; o_done 1.
- IDLE -> RUN when i_en=1. The period shadow register is loaded from i_period on that clock.
- RUN: on each tick, if count == shadow, the channel expires:
  - o_expire pulses, o_irq is set, count returns to 0.
  - If i_cont=1, shadow reloads from i_period and the channel stays in RUN.
  - Otherwise it goes to DONE.
  - If count != shadow, count increments by 1.
- Period 0: the channel expires on every tick. Period 2^WIDTH-1: count reaches all-ones then expires; the counter never wraps without expiring.
- i_period changes mid-run take effect only at the next load or reload (no glitching of the current interval).
- DONE -> RUN on i_irq_clear while i_en=1. This restarts a one-shot, matching legacy core behaviour. Shadow reloads on that clock.
- Any state -> IDLE when i_en=0: count cleared, o_done cleared. o_irq is retained until i_irq_clear.
- i_irq_clear clears o_irq. If the same clock has an expiry on that channel, set wins: o_irq stays 1 and the event is not lost.
- i_cont changing while in RUN affects the next expiry only.
- Channels are fully independent apart from the shared tick.

## Timing
- Reset values: o_irq=0, o_irq_any=0, o_expire=0, o_count=0, o_done=0. All FSMs are in IDLE. Prescaler is loaded with i_prescale.
- Reset has priority over all inputs. Asserting reset mid-interval discards the count and flags on the next edge.
- Enable-to-RUN: 1 clock. First count increment occurs on the first tick after entering RUN.
- Expiry: o_expire, o_irq and o_count=0 are all visible in the clock after the tick edge at which count==shadow. o_done follows on the same edge (one-shot).
- Interval: period P with prescale S gives an expiry every (P+1)*(S+1) clocks in continuous mode.
- o_irq_any lags o_irq by 1 clock.
- Clear-to-flag-low: 1 clock.

## Configuration
- TIMER_MULTI_CAPTURE_EN: when defined, adds:
  - input i_capture (CH bits)
  - output o_capture (CH*WIDTH bits, reset 0)
- With capture enabled, i_capture[k]=1 latches channel k's current o_count into o_capture[k] on that edge, in any state.
- Capture on the expiry edge latches the pre-reset value (equal to shadow).
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

## Test plan
- Reset, WIDTH=16, CH=4, prescale=0, ch0 period=5, continuous, enable -> first o_expire[0] 7 clocks after enable edge, then every 6 clocks; o_irq[0] stays 1.
- Ch1 one-shot, period=3, prescale=1 -> single expiry at 8 clocks after RUN; o_done[1]=1, count holds 0. i_irq_clear -> o_irq[1]=0, channel restarts, second expiry 8 clocks later.
- Ch2 period=0, prescale=2 -> o_expire[2] every 3 clocks. i_irq_clear coincident with an expiry -> o_irq[2] remains 1.
- Ch3 running, period changed 10->2 mid-interval -> current interval completes at 10; subsequent intervals use 2. Deassert i_en -> count 0, o_irq held.
- Sync reset asserted at count=4 on all channels -> next edge: all outputs 0, all FSMs in IDLE. o_irq_any drops 1 clock after o_irq.
- With TIMER_MULTI_CAPTURE_EN defined, ch0 period=9, i_capture[0] at count=6 -> o_capture[0]=6; capture on the expiry edge -> 9.

Source files
------------

// File: rtl/timer_multi_core.sv
// ---------------------------------------------------------------------------
// timer_multi_core
//   CH independent WIDTH-bit interval up-counters sharing one programmable
//   prescaler. Each channel runs one-shot or continuous, raises a one-clock
//   expiry pulse and a sticky interrupt flag that is cleared per channel.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_prescale   tick divider: one tick every i_prescale+1 clocks
//   i_en         per-channel enable (level); low forces the channel idle
//   i_cont       per-channel mode: 1 continuous, 0 one-shot
//   i_irq_clear  per-channel interrupt clear strobe; also restarts a
//                halted one-shot channel while enabled
//   i_period     per-channel period, channel k in [k*WIDTH +: WIDTH]
//   o_irq        sticky per-channel interrupt flags
//   o_irq_any    registered OR of o_irq (one clock behind)
//   o_expire     one-clock pulse per expiry
//   o_count      live counter values, channel k in [k*WIDTH +: WIDTH]
//   o_done       one-shot channel has expired and is halted
//
// Optional build macro TIMER_MULTI_CAPTURE_EN adds:
//   i_capture    per-channel capture strobe
//   o_capture    per-channel captured o_count, channel k in [k*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module timer_multi_core #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int PRE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PRE_W-1:0]      i_prescale,
    input  logic [CH-1:0]         i_en,
    input  logic [CH-1:0]         i_cont,
    input  logic [CH-1:0]         i_irq_clear,
    input  logic [CH*WIDTH-1:0]   i_period,
    output logic [CH-1:0]         o_irq,
    output logic                  o_irq_any,
    output logic [CH-1:0]         o_expire,
    output logic [CH*WIDTH-1:0]   o_count,
    output logic [CH-1:0]         o_done
`ifdef TIMER_MULTI_CAPTURE_EN
    ,
    input  logic [CH-1:0]         i_capture,
    output logic [CH*WIDTH-1:0]   o_capture
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shared prescaler: a new i_prescale is only picked up on reload,
    // so the tick currently in progress is never shortened or stretched.
    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic             r_irq_any;

    assign w_tick = (r_pre == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre <= i_prescale;
        end else if (w_tick) begin
            r_pre <= i_prescale;
        end else begin
            r_pre <= r_pre - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_any <= 1'b0;
        end else begin
            r_irq_any <= |o_irq;
        end
    end

    assign o_irq_any = r_irq_any;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] w_count_nxt;
        logic [WIDTH-1:0] r_shadow;
        logic [WIDTH-1:0] w_shadow_nxt;
        logic             r_irq;
        logic             w_irq_nxt;
        logic             r_expire;
        logic             w_fire;
        logic [WIDTH-1:0] w_period;

        assign w_period = i_period[k*WIDTH +: WIDTH];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state  <= ST_IDLE;
                r_count  <= '0;
                r_shadow <= '0;
                r_irq    <= 1'b0;
                r_expire <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_count  <= w_count_nxt;
                r_shadow <= w_shadow_nxt;
                r_irq    <= w_irq_nxt;
                r_expire <= w_fire;
            end
        end

        // The counter is compared against the shadow copy of the period,
        // never against i_period, so a period write mid-interval cannot
        // cut the running interval short; count never exceeds the shadow,
        // hence it cannot wrap without expiring.
        always_comb begin
            w_state_nxt  = r_state;
            w_count_nxt  = r_count;
            w_shadow_nxt = r_shadow;
            w_fire       = 1'b0;
            if (!i_en[k]) begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt  = ST_RUN;
                        w_shadow_nxt = w_period;
                        w_count_nxt  = '0;
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            if (r_count == r_shadow) begin
                                w_fire      = 1'b1;
                                w_count_nxt = '0;
                                if (i_cont[k]) begin
                                    w_shadow_nxt = w_period;
                                end else begin
                                    w_state_nxt = ST_DONE;
                                end
                            end else begin
                                w_count_nxt = r_count + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        w_count_nxt = '0;
                        if (i_irq_clear[k]) begin
                            w_state_nxt  = ST_RUN;
                            w_shadow_nxt = w_period;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                    end
                endcase
            end
            // An expiry on the same clock as a clear keeps the flag set.
            w_irq_nxt = w_fire | (r_irq & ~i_irq_clear[k]);
        end

        assign o_count[k*WIDTH +: WIDTH] = r_count;
        assign o_irq[k]                  = r_irq;
        assign o_expire[k]               = r_expire;
        assign o_done[k]                 = (r_state == ST_DONE);

`ifdef TIMER_MULTI_CAPTURE_EN
        logic [WIDTH-1:0] r_capture;

        // Samples the registered count, so a capture on the expiry edge
        // sees the pre-reset value (equal to the shadow).
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_capture <= '0;
            end else if (i_capture[k]) begin
                r_capture <= r_count;
            end
        end

        assign o_capture[k*WIDTH +: WIDTH] = r_capture;
`endif
    end

endmodule

// File: tb/tb_timer_multi_core.sv
// ---------------------------------------------------------------------------
// tb_timer_multi_core
//   Self-checking bench for timer_multi_core (WIDTH=16, CH=4) plus a narrow
//   WIDTH=3 single-channel instance for the all-ones period boundary.
//   A rule-level reference model predicts every output each clock; directed
//   sequences check latencies, intervals, set-wins clear and reset, then a
//   randomized phase exercises all channels. Honours TIMER_MULTI_CAPTURE_EN.
// ---------------------------------------------------------------------------
module tb_timer_multi_core;

    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int PRE_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [PRE_W-1:0]    prescale;
    logic [CH-1:0]       en, cont, clr;
    logic [CH*WIDTH-1:0] period;
    logic [CH-1:0]       irq, expire, done;
    logic                irq_any;
    logic [CH*WIDTH-1:0] count;

    logic                en_w, cont_w, clr_w;
    logic [2:0]          period_w, count_w;
    logic                irq_w, any_w, exp_w, done_w;

`ifdef TIMER_MULTI_CAPTURE_EN
    logic [CH-1:0]       cap;
    logic [CH*WIDTH-1:0] capture;
    logic                cap_w;
    logic [2:0]          capture_w;
`endif

    always #5 clk = ~clk;

    timer_multi_core #(.WIDTH(WIDTH), .CH(CH), .PRE_W(PRE_W)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_prescale  (prescale),
        .i_en        (en),
        .i_cont      (cont),
        .i_irq_clear (clr),
        .i_period    (period),
        .o_irq       (irq),
        .o_irq_any   (irq_any),
        .o_expire    (expire),
        .o_count     (count),
        .o_done      (done)
`ifdef TIMER_MULTI_CAPTURE_EN
        ,
        .i_capture   (cap),
        .o_capture   (capture)
`endif
    );

    timer_multi_core #(.WIDTH(3), .CH(1), .PRE_W(PRE_W)) u_w3 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_prescale  (prescale),
        .i_en        (en_w),
        .i_cont      (cont_w),
        .i_irq_clear (clr_w),
        .i_period    (period_w),
        .o_irq       (irq_w),
        .o_irq_any   (any_w),
        .o_expire    (exp_w),
        .o_count     (count_w),
        .o_done      (done_w)
`ifdef TIMER_MULTI_CAPTURE_EN
        ,
        .i_capture   (cap_w),
        .o_capture   (capture_w)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: channel mode 0=idle 1=run 2=done.
    int               m_mode [CH];
    logic [WIDTH-1:0] m_cnt  [CH];
    logic [WIDTH-1:0] m_shd  [CH];
    bit               m_irq  [CH];
    bit               m_exp  [CH];
    bit               m_any;
    int unsigned      m_cyc;
    int unsigned      m_s;
`ifdef TIMER_MULTI_CAPTURE_EN
    logic [WIDTH-1:0] m_cap  [CH];
`endif

    task automatic model_step();
        bit tick;
        bit any_n;
        bit fire;
        logic [WIDTH-1:0] p;
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                m_mode[k] = 0; m_cnt[k] = '0; m_shd[k] = '0;
                m_irq[k] = 1'b0; m_exp[k] = 1'b0;
`ifdef TIMER_MULTI_CAPTURE_EN
                m_cap[k] = '0;
`endif
            end
            m_any = 1'b0;
            m_cyc = 0;
            m_s   = int'(prescale);
            return;
        end
        // Ticks fall on every (S+1)-th clock after reset, the first S clocks in.
        tick = ((m_cyc % (m_s + 1)) == m_s);
        m_cyc++;
        any_n = 1'b0;
        for (int k = 0; k < CH; k++) any_n |= m_irq[k];
        for (int k = 0; k < CH; k++) begin
            p    = period[k*WIDTH +: WIDTH];
            fire = 1'b0;
`ifdef TIMER_MULTI_CAPTURE_EN
            if (cap[k]) m_cap[k] = m_cnt[k];
`endif
            if (!en[k]) begin
                m_mode[k] = 0;
                m_cnt[k]  = '0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1;
                m_shd[k]  = p;
            end else if (m_mode[k] == 1) begin
                if (tick && m_cnt[k] == m_shd[k]) begin
                    fire     = 1'b1;
                    m_cnt[k] = '0;
                    if (cont[k]) m_shd[k] = p;
                    else         m_mode[k] = 2;
                end else if (tick) begin
                    m_cnt[k] = m_cnt[k] + 1'b1;
                end
            end else if (clr[k]) begin
                m_mode[k] = 1;
                m_shd[k]  = p;
            end
            m_exp[k] = fire;
            if (fire)        m_irq[k] = 1'b1;
            else if (clr[k]) m_irq[k] = 1'b0;
        end
        m_any = any_n;
    endtask

    task automatic compare();
        logic [CH*WIDTH-1:0] ec;
        logic [CH-1:0]       ei, ee, ed;
`ifdef TIMER_MULTI_CAPTURE_EN
        logic [CH*WIDTH-1:0] ecap;
`endif
        for (int k = 0; k < CH; k++) begin
            ec[k*WIDTH +: WIDTH] = m_cnt[k];
            ei[k] = m_irq[k];
            ee[k] = m_exp[k];
            ed[k] = (m_mode[k] == 2);
`ifdef TIMER_MULTI_CAPTURE_EN
            ecap[k*WIDTH +: WIDTH] = m_cap[k];
`endif
        end
        check_eq("model_count",   64'(count),   64'(ec));
        check_eq("model_irq",     64'(irq),     64'(ei));
        check_eq("model_expire",  64'(expire),  64'(ee));
        check_eq("model_done",    64'(done),    64'(ed));
        check_eq("model_irq_any", 64'(irq_any), 64'(m_any));
`ifdef TIMER_MULTI_CAPTURE_EN
        check_eq("model_capture", 64'(capture), 64'(ecap));
`endif
    endtask

    // Inputs are driven at the falling edge; outputs sampled at the next one.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_period(input int k, input logic [WIDTH-1:0] v);
        period[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset(input int unsigned s);
        rst = 1'b1; prescale = PRE_W'(s);
        en = '0; cont = '0; clr = '0; period = '0;
        en_w = 1'b0; cont_w = 1'b0; clr_w = 1'b0; period_w = '0;
`ifdef TIMER_MULTI_CAPTURE_EN
        cap = '0; cap_w = 1'b0;
`endif
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_expire(input int ch, input int maxc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!expire[ch] && n < maxc);
        if (!expire[ch]) check_eq($sformatf("timeout_ch%0d", ch), 64'(expire[ch]), 64'd1);
    endtask

    initial begin
        int n;
        int maxc;

        @(negedge clk);

        // Continuous ch0, then mid-run period change on ch3 (prescale 0).
        do_reset(0);
        check_eq("rst_count",   64'(count),   64'd0);
        check_eq("rst_irq",     64'(irq),     64'd0);
        check_eq("rst_done",    64'(done),    64'd0);
        check_eq("rst_expire",  64'(expire),  64'd0);
        check_eq("rst_irq_any", 64'(irq_any), 64'd0);
        set_period(0, 16'd5); cont[0] = 1'b1; en[0] = 1'b1;
        run_until_expire(0, 20, n);
        check_eq("ch0_first_lat", 64'(n), 64'd7);
        run_until_expire(0, 20, n);
        check_eq("ch0_interval", 64'(n), 64'd6);
        check_eq("ch0_irq_sticky", 64'(irq[0]), 64'd1);
        set_period(3, 16'd10); cont[3] = 1'b1; en[3] = 1'b1;
        repeat (4) cycle();
        set_period(3, 16'd2);
        run_until_expire(3, 30, n);
        check_eq("ch3_old_period", 64'(n), 64'd8);
        run_until_expire(3, 30, n);
        check_eq("ch3_new_period", 64'(n), 64'd3);
        en[3] = 1'b0;
        cycle();
        check_eq("ch3_dis_count", 64'(count[3*WIDTH +: WIDTH]), 64'd0);
        check_eq("ch3_dis_irq_held", 64'(irq[3]), 64'd1);

        // All-ones period on the 3-bit instance: reaches 7, then expires.
        cont_w = 1'b1; period_w = 3'd7; en_w = 1'b1;
        n = 0; maxc = 0;
        do begin
            cycle();
            n++;
            if (int'(count_w) > maxc) maxc = int'(count_w);
        end while (!exp_w && n < 20);
        check_eq("w3_expired", 64'(exp_w), 64'd1);
        check_eq("w3_first_lat", 64'(n), 64'd9);
        check_eq("w3_max_count", 64'(maxc), 64'd7);
        check_eq("w3_count_zero", 64'(count_w), 64'd0);
        check_eq("w3_irq", 64'(irq_w), 64'd1);
        check_eq("w3_done_cont", 64'(done_w), 64'd0);
        cycle();
        check_eq("w3_irq_any", 64'(any_w), 64'd1);

        // Clear everything: flags drop in one clock, irq_any one clock later.
        en = '0; clr = '1;
        cycle();
        clr = '0;
        check_eq("clr_irq_low", 64'(irq), 64'd0);
        check_eq("clr_any_lag", 64'(irq_any), 64'd1);
        cycle();
        check_eq("clr_any_low", 64'(irq_any), 64'd0);

        // One-shot ch1, prescale 1, restart by clear.
        do_reset(1);
        set_period(1, 16'd3); cont[1] = 1'b0; en[1] = 1'b1;
        run_until_expire(1, 30, n);
        check_eq("ch1_oneshot_lat", 64'(n), 64'd8);
        check_eq("ch1_done", 64'(done[1]), 64'd1);
        cycle();
        check_eq("ch1_hold_count", 64'(count[1*WIDTH +: WIDTH]), 64'd0);
        check_eq("ch1_still_done", 64'(done[1]), 64'd1);
        clr[1] = 1'b1;
        cycle();
        clr[1] = 1'b0;
        check_eq("ch1_clr_irq", 64'(irq[1]), 64'd0);
        check_eq("ch1_restart", 64'(done[1]), 64'd0);
        run_until_expire(1, 30, n);
        check_eq("ch1_restart_lat", 64'(n), 64'd8);

        // Period 0, prescale 2: expiry every 3 clocks; clear loses to expiry.
        do_reset(2);
        set_period(2, 16'd0); cont[2] = 1'b1; en[2] = 1'b1;
        run_until_expire(2, 20, n);
        check_eq("ch2_any_lag", 64'(irq_any), 64'd0);
        run_until_expire(2, 20, n);
        check_eq("ch2_interval", 64'(n), 64'd3);
        cycle();
        cycle();
        clr[2] = 1'b1;
        cycle();
        clr[2] = 1'b0;
        check_eq("coinc_expire", 64'(expire[2]), 64'd1);
        check_eq("coinc_set_wins", 64'(irq[2]), 64'd1);

        // Reset in the middle of an interval on all channels.
        do_reset(0);
        for (int k = 0; k < CH; k++) set_period(k, 16'd9);
        cont = '1; en = '1;
        repeat (5) cycle();
        check_eq("pre_rst_count", 64'(count), 64'h0004_0004_0004_0004);
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = '0;
        check_eq("mid_rst_count", 64'(count), 64'd0);
        check_eq("mid_rst_done", 64'(done), 64'd0);

`ifdef TIMER_MULTI_CAPTURE_EN
        do_reset(0);
        set_period(0, 16'd9); cont[0] = 1'b1; en[0] = 1'b1;
        repeat (7) cycle();
        check_eq("cap_pre_count", 64'(count[WIDTH-1:0]), 64'd6);
        cap[0] = 1'b1;
        cycle();
        cap[0] = 1'b0;
        check_eq("cap_mid", 64'(capture[WIDTH-1:0]), 64'd6);
        n = 0;
        while (count[WIDTH-1:0] != 16'd9 && n < 20) begin
            cycle();
            n++;
        end
        cap[0] = 1'b1;
        cycle();
        cap[0] = 1'b0;
        check_eq("cap_exp_pulse", 64'(expire[0]), 64'd1);
        check_eq("cap_on_expiry", 64'(capture[WIDTH-1:0]), 64'd9);
        check_eq("cap_w_idle", 64'(capture_w), 64'd0);
`endif

        // Randomized phase against the model.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset($urandom_range(0, 3));
            en = '1;
            for (int k = 0; k < CH; k++) set_period(k, WIDTH'($urandom_range(0, 7)));
            for (int c = 0; c < 300; c++) begin
                rst = ($urandom_range(0, 99) == 0);
                for (int k = 0; k < CH; k++) begin
                    if ($urandom_range(0, 19) == 0) en[k] = ~en[k];
                    if ($urandom_range(0, 9) == 0)  cont[k] = 1'($urandom_range(0, 1));
                    clr[k] = ($urandom_range(0, 7) == 0);
                    if ($urandom_range(0, 15) == 0)
                        set_period(k, ($urandom_range(0, 15) == 0) ? '1 : WIDTH'($urandom_range(0, 7)));
`ifdef TIMER_MULTI_CAPTURE_EN
                    cap[k] = ($urandom_range(0, 5) == 0);
`endif
                end
                cycle();
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
